// File: rtl/bmp_frame_arbiter_if.sv
// Bus bundle between the two BMP slave ports, the master FIFO port and the
// arbiter status outputs.
interface bmp_frame_arbiter_if;
    logic        slv0_data_valid;
    logic [31:0] slv0_data;
    logic        slv0_mode;
    logic        slv0_ready;
    logic        slv1_data_valid;
    logic [31:0] slv1_data;
    logic        slv1_mode;
    logic        slv1_ready;
    logic        mstr0_ready;
    logic        mstr0_data_valid;
    logic [31:0] data_to_master;
    logic        mode;
    logic [1:0]  grant;
    logic        done;
    logic        hdr_err;
    logic [1:0]  fsm_state;

    // A word moves on a rising edge where valid and ready are both high; the
    // producer holds valid and data stable until then, and ready may depend
    // combinationally on the downstream ready.
    modport master (
        input  slv0_data_valid, slv0_data, slv0_mode,
        input  slv1_data_valid, slv1_data, slv1_mode,
        input  mstr0_ready,
        output slv0_ready, slv1_ready, mstr0_data_valid, data_to_master,
        output mode, grant, done, hdr_err, fsm_state
    );

    modport slave (
        output slv0_data_valid, slv0_data, slv0_mode,
        output slv1_data_valid, slv1_data, slv1_mode,
        output mstr0_ready,
        input  slv0_ready, slv1_ready, mstr0_data_valid, data_to_master,
        input  mode, grant, done, hdr_err, fsm_state
    );
endinterface

// File: rtl/bmp_frame_arbiter.sv
// Grants one of two slaves for a whole BMP file, forwards its words through a
// one-entry output register, and hands the bus over round-robin at frame end.
module bmp_frame_arbiter #(
    parameter int          DATA_BUS_SIZE  = 32,
    parameter int unsigned MAX_FILE_BYTES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bmp_frame_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, HDR0 = 2'd1, HDR1 = 2'd2, BODY = 2'd3} state_t;

    state_t                   state;
    logic [1:0]               grant;
    logic                     rr;
    logic [15:0]              size_lo;
    logic [15:0]              sig;
    logic [1:0]               last_lanes;
    logic [30:0]              total_words;
    logic [30:0]              word_cnt;
    logic                     mode_q;
    logic                     out_valid;
    logic [DATA_BUS_SIZE-1:0] out_data;
    logic                     done_q;
    logic                     hdr_err_q;

    logic                     sel;
    logic                     in_valid;
    logic [DATA_BUS_SIZE-1:0] in_data;
    logic                     in_mode;
    logic                     can_load;
    logic                     rdy0;
    logic                     rdy1;
    logic                     xfer;
    logic [31:0]              hdr_size;
    logic [30:0]              hdr_words;
    logic                     hdr_bad;
    logic                     body_last;
    logic [DATA_BUS_SIZE-1:0] masked;
    logic [DATA_BUS_SIZE-1:0] word_out;

    assign sel       = grant[1];
    assign in_valid  = sel ? bus.slv1_data_valid : bus.slv0_data_valid;
    assign in_data   = sel ? bus.slv1_data : bus.slv0_data;
    assign in_mode   = sel ? bus.slv1_mode : bus.slv0_mode;
    assign can_load  = !out_valid || bus.mstr0_ready;
    assign rdy0      = grant[0] && (state != IDLE) && can_load;
    assign rdy1      = grant[1] && (state != IDLE) && can_load;
    assign xfer      = in_valid && (sel ? rdy1 : rdy0);

    // Header word 1 carries the upper half of the little-endian file size.
    assign hdr_size  = {in_data[15:0], size_lo};
    assign hdr_words = {1'b0, hdr_size[31:2]} + {30'd0, |hdr_size[1:0]};
    assign hdr_bad   = (sig != 16'h4D42) || (hdr_size < 32'd8) || (hdr_size > MAX_FILE_BYTES);
    assign body_last = (state == BODY) && (word_cnt == total_words - 31'd1);

    // Bytes beyond the end of the file in the final word are zeroed.
    always_comb begin
        masked = '0;
        for (int k = 0; k < DATA_BUS_SIZE / 8; k++) begin
            if (last_lanes == 2'd0 || 2'(k) < last_lanes)
                masked[8*k +: 8] = in_data[8*k +: 8];
        end
    end

    assign word_out = body_last ? masked : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            grant       <= 2'b00;
            rr          <= 1'b0;
            size_lo     <= 16'd0;
            sig         <= 16'd0;
            last_lanes  <= 2'd0;
            total_words <= 31'd0;
            word_cnt    <= 31'd0;
            mode_q      <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            done_q      <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (xfer) begin
                out_data  <= word_out;
                out_valid <= 1'b1;
            end else if (bus.mstr0_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.slv0_data_valid || bus.slv1_data_valid) begin
                        if (bus.slv0_data_valid && (!bus.slv1_data_valid || !rr))
                            grant <= 2'b01;
                        else
                            grant <= 2'b10;
                        hdr_err_q <= 1'b0;
                        state     <= HDR0;
                    end
                end
                HDR0: begin
                    if (xfer) begin
                        size_lo <= in_data[31:16];
                        sig     <= in_data[15:0];
                        mode_q  <= in_mode;
                        state   <= HDR1;
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        last_lanes  <= hdr_size[1:0];
                        total_words <= hdr_words;
                        word_cnt    <= 31'd2;
                        // A bad header ends the frame here, just like a two-word file.
                        if (hdr_bad || hdr_words == 31'd2) begin
                            hdr_err_q <= hdr_bad;
                            done_q    <= 1'b1;
                            grant     <= 2'b00;
                            rr        <= ~sel;
                            state     <= IDLE;
                        end else begin
                            state <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (xfer) begin
                        word_cnt <= word_cnt + 31'd1;
                        if (body_last) begin
                            done_q <= 1'b1;
                            grant  <= 2'b00;
                            rr     <= ~sel;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.slv0_ready       = rdy0;
    assign bus.slv1_ready       = rdy1;
    assign bus.mstr0_data_valid = out_valid;
    assign bus.data_to_master   = out_data;
    assign bus.mode             = mode_q;
    assign bus.grant            = grant;
    assign bus.done             = done_q;
    assign bus.hdr_err          = hdr_err_q;
    assign bus.fsm_state        = state;
endmodule

// File: tb/tb_bmp_frame_arbiter.sv
// Bench for bmp_frame_arbiter: a cycle table for single and back-to-back
// frames, then scoreboarded sequences for arbitration, stalls, errors and reset.
module tb_bmp_frame_arbiter;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bmp_frame_arbiter_if bus();

    bmp_frame_arbiter #(.DATA_BUS_SIZE(32), .MAX_FILE_BYTES(1000000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    task automatic idle_inputs();
        bus.slv0_data_valid = 1'b0;
        bus.slv0_data       = 32'h0;
        bus.slv0_mode       = 1'b0;
        bus.slv1_data_valid = 1'b0;
        bus.slv1_data       = 32'h0;
        bus.slv1_mode       = 1'b0;
        bus.mstr0_ready     = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " mvalid"},  32'(bus.mstr0_data_valid), 32'h0);
        chk({tag, " data"},    bus.data_to_master,        32'h0);
        chk({tag, " grant"},   32'(bus.grant),            32'h0);
        chk({tag, " done"},    32'(bus.done),             32'h0);
        chk({tag, " hdr_err"}, 32'(bus.hdr_err),          32'h0);
        chk({tag, " mode"},    32'(bus.mode),             32'h0);
        chk({tag, " ready0"},  32'(bus.slv0_ready),       32'h0);
        chk({tag, " ready1"},  32'(bus.slv1_ready),       32'h0);
        chk({tag, " state"},   32'(bus.fsm_state),        32'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check_reset_outputs(tag);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];      // {is_last, word}
    bit          mon_en    = 1'b0;
    bit          prev_free = 1'b1;
    logic [31:0] held      = 32'h0;

    task automatic push_frame(input logic [31:0] w[8], input int n, input logic [31:0] last_word);
        for (int i = 0; i < n - 1; i++) exp_q.push_back({1'b0, w[i]});
        exp_q.push_back({1'b1, last_word});
    endtask

    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (bus.mstr0_data_valid && prev_free) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected word", bus.data_to_master, 32'hFFFF_FFFF);
                end else begin
                    chk("sb word", bus.data_to_master, exp_q[0][31:0]);
                    chk("sb done", 32'(bus.done), 32'(exp_q[0][32]));
                end
            end else begin
                chk("sb no done", 32'(bus.done), 32'h0);
            end
            if (!prev_free) begin
                chk("sb held valid", 32'(bus.mstr0_data_valid), 32'h1);
                chk("sb held data", bus.data_to_master, held);
            end
            if (bus.mstr0_data_valid && !bus.mstr0_ready)
                chk("sb stall ready", {30'd0, bus.slv1_ready, bus.slv0_ready}, 32'h0);
            chk("sb ready vs grant", {30'd0, bus.slv1_ready & ~bus.grant[1], bus.slv0_ready & ~bus.grant[0]}, 32'h0);
            if (bus.mstr0_data_valid && bus.mstr0_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            prev_free = !bus.mstr0_data_valid || bus.mstr0_ready;
            held      = bus.data_to_master;
        end else begin
            prev_free = 1'b1;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_frame(input int s, input logic [31:0] w[8], input int n, input logic m);
        int  i   = 0;
        int  cyc = 0;
        logic rdy;
        while (i < n) begin
            @(negedge clk);
            if (s == 0) begin
                bus.slv0_data_valid = 1'b1;
                bus.slv0_data       = w[i];
                bus.slv0_mode       = m;
            end else begin
                bus.slv1_data_valid = 1'b1;
                bus.slv1_data       = w[i];
                bus.slv1_mode       = m;
            end
            #1;
            rdy = (s == 0) ? bus.slv0_ready : bus.slv1_ready;
            if (rdy) i++;
            cyc++;
            if (cyc > 200) begin
                bound_fail($sformatf("send slv%0d", s));
                break;
            end
        end
        @(negedge clk);
        if (s == 0) bus.slv0_data_valid = 1'b0;
        else        bus.slv1_data_valid = 1'b0;
    endtask

    // Follows one frame end: checks release, the single idle cycle and the
    // next owner; optionally plays a 1,0,0,1 master-ready pattern afterwards.
    task automatic watch_handover(input string tag, input logic exp_err, input logic [1:0] nxt, input bit pat);
        logic pat_bits[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   phase = 0;
        int   k     = 0;
        int   cyc   = 0;
        while (!(phase == 2 && (!pat || k == 4))) begin
            @(negedge clk);
            if (phase == 2 && pat && k < 4) begin
                bus.mstr0_ready = pat_bits[k];
                k++;
            end else begin
                bus.mstr0_ready = 1'b1;
            end
            #1;
            if (phase == 1) begin
                chk({tag, " next grant"}, 32'(bus.grant), 32'(nxt));
                chk({tag, " hdr_err cleared"}, 32'(bus.hdr_err), 32'h0);
                phase = 2;
            end else if (phase == 0 && bus.done) begin
                chk({tag, " released"}, 32'(bus.grant), 32'h0);
                chk({tag, " hdr_err"}, 32'(bus.hdr_err), 32'(exp_err));
                phase = 1;
            end
            cyc++;
            if (cyc > 200) begin
                bound_fail({tag, " handover"});
                break;
            end
        end
        bus.mstr0_ready = 1'b1;
    endtask

    task automatic drain(input string tag);
        int c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        chk({tag, " drained"}, 32'(exp_q.size()), 32'h0);
    endtask

    // ---------------- cycle table ----------------
    typedef struct {
        logic [4:0]  in_f;   // s0v s0m s1v s1m mready
        logic [31:0] s0d;
        logic [31:0] s1d;
        logic [5:0]  exp_f;  // ready0 ready1 mvalid done mode hdr_err
        logic [1:0]  gnt;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[12];

    task automatic apply_vec(input vec_t v, input int idx);
        bus.slv0_data_valid = v.in_f[4];
        bus.slv0_mode       = v.in_f[3];
        bus.slv1_data_valid = v.in_f[2];
        bus.slv1_mode       = v.in_f[1];
        bus.mstr0_ready     = v.in_f[0];
        bus.slv0_data       = v.s0d;
        bus.slv1_data       = v.s1d;
        #1;
        chk($sformatf("v%0d ready0", idx), 32'(bus.slv0_ready), 32'(v.exp_f[5]));
        chk($sformatf("v%0d ready1", idx), 32'(bus.slv1_ready), 32'(v.exp_f[4]));
        @(negedge clk);
        #1;
        chk($sformatf("v%0d mvalid", idx),  32'(bus.mstr0_data_valid), 32'(v.exp_f[3]));
        chk($sformatf("v%0d done", idx),    32'(bus.done),             32'(v.exp_f[2]));
        chk($sformatf("v%0d mode", idx),    32'(bus.mode),             32'(v.exp_f[1]));
        chk($sformatf("v%0d hdr_err", idx), 32'(bus.hdr_err),          32'(v.exp_f[0]));
        chk($sformatf("v%0d grant", idx),   32'(bus.grant),            32'(v.gnt));
        if (v.exp_f[3]) chk($sformatf("v%0d data", idx), bus.data_to_master, v.dout);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] fa[8];
        logic [31:0] fb[8];

        // slv0 10-byte file, then slv0+slv1 contend with rr on slv1 (8-byte, mode 1), then slv0 8-byte.
        tbl[0]  = '{5'b10001, 32'h000A4D42, 32'h0,        6'b000000, 2'b01, 32'h0};
        tbl[1]  = '{5'b10001, 32'h000A4D42, 32'h0,        6'b101000, 2'b01, 32'h000A4D42};
        tbl[2]  = '{5'b10001, 32'h00000000, 32'h0,        6'b101000, 2'b01, 32'h00000000};
        tbl[3]  = '{5'b10001, 32'hCCDDAABB, 32'h0,        6'b101100, 2'b00, 32'h0000AABB};
        tbl[4]  = '{5'b00001, 32'h0,        32'h0,        6'b000000, 2'b00, 32'h0};
        tbl[5]  = '{5'b10111, 32'h00084D42, 32'h00084D42, 6'b000000, 2'b10, 32'h0};
        tbl[6]  = '{5'b10111, 32'h00084D42, 32'h00084D42, 6'b011010, 2'b10, 32'h00084D42};
        tbl[7]  = '{5'b10111, 32'h00084D42, 32'h11220000, 6'b011110, 2'b00, 32'h11220000};
        tbl[8]  = '{5'b10001, 32'h00084D42, 32'h0,        6'b000010, 2'b01, 32'h0};
        tbl[9]  = '{5'b10001, 32'h00084D42, 32'h0,        6'b101000, 2'b01, 32'h00084D42};
        tbl[10] = '{5'b10001, 32'hAABB0000, 32'h0,        6'b101100, 2'b00, 32'hAABB0000};
        tbl[11] = '{5'b00001, 32'h0,        32'h0,        6'b000000, 2'b00, 32'h0};

        rst_n = 1'b0;
        idle_inputs();
        #3;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) apply_vec(tbl[i], i);

        // Both slaves request together after reset; slv1 sees a stalling master.
        do_reset("rst2");
        mon_en = 1'b1;
        fa = '{32'h00104D42, 32'h0, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 32'h0, 32'h0};
        fb = '{32'h00104D42, 32'h0, 32'h33333333, 32'h44444444, 32'h0, 32'h0, 32'h0, 32'h0};
        push_frame(fa, 4, 32'h22222222);
        push_frame(fb, 4, 32'h44444444);
        fork
            send_frame(0, fa, 4, 1'b0);
            send_frame(1, fb, 4, 1'b0);
            watch_handover("arb", 1'b0, 2'b10, 1'b1);
        join
        drain("arb");

        // Bad signature from slv0, then an 11-byte slv1 file with a 3-lane tail.
        fa = '{32'h00104D41, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        fb = '{32'h000B4D42, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        push_frame(fa, 2, 32'h00000000);
        push_frame(fb, 3, 32'h00345678);
        fork
            send_frame(0, fa, 2, 1'b0);
            send_frame(1, fb, 3, 1'b1);
            watch_handover("err", 1'b1, 2'b10, 1'b0);
        join
        drain("err");
        chk("err frame mode", 32'(bus.mode), 32'h1);

        // Reset while word 3 of a 20-byte slv0 file sits in the output register.
        mon_en = 1'b0;
        @(negedge clk);
        bus.slv0_data_valid = 1'b1;
        bus.slv0_data       = 32'h00144D42;
        bus.slv0_mode       = 1'b1;
        bus.mstr0_ready     = 1'b1;
        repeat (2) @(negedge clk);
        bus.slv0_data = 32'h00000000;
        @(negedge clk);
        bus.slv0_data = 32'h55555555;
        @(negedge clk);
        #1;
        chk("abort pre data", bus.data_to_master, 32'h55555555);
        chk("abort pre grant", 32'(bus.grant), 32'h1);
        chk("abort pre mode", 32'(bus.mode), 32'h1);
        #1;
        rst_n = 1'b0;
        bus.slv0_data_valid = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();

        mon_en = 1'b1;
        fa = '{32'h00084D42, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        fb = '{32'h00084D42, 32'h99990000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        push_frame(fa, 2, 32'h00000000);
        push_frame(fb, 2, 32'h99990000);
        fork
            send_frame(0, fa, 2, 1'b0);
            send_frame(1, fb, 2, 1'b0);
            watch_handover("post", 1'b0, 2'b10, 1'b0);
        join
        drain("post");
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
